inst_loader: RTL and testbench

Writer side of the instruction-memory interface. It receives a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words. Each word goes to the instruction memory write port at consecutive word addresses from BASE_ADDR. The CPU is held in reset via cpu_rst until a complete program is committed, so fetch only reads fully loaded memory.

---
 rtl/loader_pkg.sv | 16 +
 rtl/byte_packer.sv | 52 +++++
 rtl/inst_loader.sv | 149 ++++++++++++++
 tb/tb_inst_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_WIDTH      = 16;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into words and emits a one-cycle
// word_valid pulse, with the packed word, after the last byte of each word.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_last,
    output logic                  o_word_valid,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [1:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_pack;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_word_valid;
    logic [DATA_WIDTH-1:0] w_merged;

    // Insert the incoming byte at its lane so the completed word is ready
    // in the same cycle as its final byte.
    always_comb begin
        w_merged = r_pack;
        w_merged[{r_cnt, 3'b000} +: 8] = i_data;
    end

    assign o_last = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

    // Byte counter, pack register and registered word output.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt        <= '0;
            r_pack       <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= o_last;
            if (i_valid) begin
                r_pack <= w_merged;
                r_cnt  <= r_cnt + 2'd1;
                if (o_last) r_word <= w_merged;
            end
        end
    end

    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory writer: takes LEN (words) then LEN*4 bytes, writes
// packed words from BASE_ADDR upward and releases the CPU reset only once
// the whole program is in memory.
module inst_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    // Words that fit between BASE_ADDR and the top of the write port.
    localparam logic [31:0] MAX_WORDS = 32'(2 ** (ADDR_WIDTH - 2) - BASE_ADDR / 4);

    state_t                r_state, w_next;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_word_idx;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_cpu_rst;

    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_start_acc;
    logic                  w_byte_vld;
    logic                  w_last;
    logic                  w_last_word;
    logic                  w_clear;
    logic                  w_word_valid;
    logic [DATA_WIDTH-1:0] w_word;

    // Full length as it stands on the cycle the high byte arrives.
    assign w_len       = {i_in_data, r_len[7:0]};
    // in_ready is always high in DATA, so in_valid alone means a transfer.
    assign w_byte_vld  = i_in_valid && (r_state == DATA);
    assign w_last_word = w_last && (r_word_idx == r_len - LEN_WIDTH'(1));
    assign w_clear     = i_rst || w_start_acc;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .i_clk        (i_clk),
        .i_clear      (w_clear),
        .i_valid      (w_byte_vld),
        .i_data       (i_in_data),
        .o_last       (w_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Session FSM: next state and state-decoded status outputs.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        o_in_ready  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next      = LEN_LO;
                    w_start_acc = 1'b1;
                end
            end
            LEN_LO: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid) w_next = LEN_HI;
            end
            LEN_HI: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (i_in_valid) begin
                    if (w_len == '0)
                        w_next = DONE;
                    else if ({{(32-LEN_WIDTH){1'b0}}, w_len} > MAX_WORDS)
                        w_next = ERR;
                    else
                        w_next = DATA;
                end
            end
            DATA: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b1;
                if (w_last_word) w_next = DONE;
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_next      = LEN_LO;
                    w_start_acc = 1'b1;
                end
            end
            ERR: begin
                o_err = 1'b1;
                if (i_start) begin
                    w_next      = LEN_LO;
                    w_start_acc = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, length latch, word index, write address and CPU reset hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_word_idx <= '0;
            r_wr_addr  <= '0;
            r_cpu_rst  <= 1'b1;
        end else begin
            r_state   <= w_next;
            // Release only after a full cycle in DONE, so the final write
            // has landed before the CPU fetches.
            r_cpu_rst <= !((r_state == DONE) && (w_next == DONE));
            if ((r_state == LEN_LO) && i_in_valid)
                r_len[7:0] <= i_in_data;
            if ((r_state == LEN_HI) && i_in_valid) begin
                r_len[LEN_WIDTH-1:8] <= i_in_data;
                r_word_idx           <= '0;
            end
            if (w_last) begin
                r_wr_addr  <= ADDR_WIDTH'(BASE_ADDR) + {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
                r_word_idx <= r_word_idx + LEN_WIDTH'(1);
            end
        end
    end

    assign o_wr_en   = w_word_valid;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = w_word;
    assign o_cpu_rst = r_cpu_rst;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader against a queue-based model of the
// expected memory writes and the cpu_rst/done/err rules.
module tb_inst_loader;

    localparam int AW    = 12;
    localparam int BASE  = 0;
    localparam int MAX_W = (1 << (AW - 2)) - BASE / 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        bit            last;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, wr_en, cpu_rst, busy, done, err;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    int  n_pass = 0, n_chk = 0;
    int  cyc = 0, start_cyc = 0, first_wr = -1, last_wr = -1, n_wr = 0;
    bit  mon_en = 0, chk_gap = 0, done_q = 0;
    wr_t exp_q[$];
    wr_t me;
    logic [31:0] prog[$];

    inst_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_cpu_rst  (cpu_rst),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Per-cycle monitor: write order/content, cpu_rst release, idle ready.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            chk("cpu_rst_rule", cpu_rst, !(done && done_q));
            if (done || err) chk("ready_idle", in_ready, 0);
            if (wr_en) begin
                chk("wr_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    me = exp_q.pop_front();
                    chk("wr_addr", wr_addr, me.a);
                    chk("wr_data", wr_data, me.d);
                    chk("done_with_last", done, me.last);
                end
                if (first_wr < 0) first_wr = cyc;
                if (chk_gap && last_wr >= 0) chk("wr_spacing", cyc - last_wr, 4);
                last_wr = cyc;
                n_wr++;
            end
            if (start && !busy) start_cyc = cyc;
            done_q = done;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int gap, input bit noise);
        int i = 0;
        int guard = 0;
        while (i < q.size() && guard < q.size() * 10 + 100) begin
            in_valid = ($urandom_range(99) >= gap);
            in_data  = in_valid ? q[i] : 8'($urandom);
            start    = noise && ($urandom_range(3) == 0);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("bytes_accepted", i, q.size());
    endtask

    task automatic wait_flag(input bit want_err);
        bit seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = want_err ? err : done;
        end
        chk(want_err ? "err_seen" : "done_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    // Runs one load of prog[] with the given LEN field and checks outcome.
    task automatic session(input logic [15:0] len, input int gap, input bit noise);
        logic [7:0]  q[$];
        logic [31:0] wd;
        wr_t         e;
        bit          bad;
        bad = (int'(len) > MAX_W);
        q.push_back(len[7:0]);
        q.push_back(len[15:8]);
        if (!bad) begin
            for (int w = 0; w < int'(len); w++) begin
                wd     = prog[w];
                e.a    = AW'(BASE + 4 * w);
                e.d    = wd;
                e.last = (w == int'(len) - 1);
                exp_q.push_back(e);
                for (int b = 0; b < 4; b++) q.push_back(wd[8*b +: 8]);
            end
        end
        n_wr     = 0;
        first_wr = -1;
        last_wr  = -1;
        chk_gap  = (gap == 0) && !noise;
        pulse_start();
        #2;
        chk("cpu_rst_on_start", cpu_rst, 1);
        chk("busy_on_start", busy, 1);
        chk("done_clr", done, 0);
        chk("err_clr", err, 0);
        send_bytes(q, gap, noise);
        wait_flag(bad);
        #2;
        if (bad) begin
            chk("err_flag", err, 1);
            chk("err_cpu_rst", cpu_rst, 1);
            chk("err_ready", in_ready, 0);
            chk("err_busy", busy, 0);
            chk("err_no_wr", n_wr, 0);
        end else begin
            chk("cpu_rst_release", cpu_rst, 0);
            chk("done_hold", done, 1);
            chk("n_wr", n_wr, int'(len));
            if (chk_gap && len != 0) chk("first_wr_latency", first_wr - start_cyc, 7);
        end
        chk("exp_drained", exp_q.size(), 0);
        chk_gap = 0;
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] wd;
        wr_t         e;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Single word from the reference stream 01 00 93 00 50 00.
        prog = {32'h0050_0093};
        session(16'd1, 0, 0);

        // Three words back-to-back, then the same program with gaps.
        prog = {$urandom, $urandom, $urandom};
        session(16'd3, 0, 0);
        session(16'd3, 40, 0);

        // Empty program and oversize length.
        session(16'd0, 0, 0);
        session(16'h0401, 0, 0);

        // Recovery from ERR with start noise during the load.
        prog = {$urandom, $urandom};
        session(16'd2, 20, 1);

        // Reset after two bytes of the second word.
        prog = {$urandom, $urandom};
        e.a = AW'(BASE); e.d = prog[0]; e.last = 0;
        exp_q.push_back(e);
        q = {8'h02, 8'h00};
        wd = prog[0];
        for (int b = 0; b < 4; b++) q.push_back(wd[8*b +: 8]);
        wd = prog[1];
        q.push_back(wd[7:0]);
        q.push_back(wd[15:8]);
        pulse_start();
        send_bytes(q, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cpu_rst", cpu_rst, 1);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_exp", exp_q.size(), 0);
        @(posedge clk); #1;

        // Fresh load from IDLE, then restart from DONE with start noise.
        prog = {$urandom, $urandom, $urandom};
        session(16'd3, 0, 0);
        prog = {$urandom, $urandom};
        session(16'd2, 0, 1);

        // Largest program that fits: last word at the top address.
        prog = {};
        for (int w = 0; w < MAX_W; w++) prog.push_back($urandom);
        session(16'(MAX_W), 0, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
